// File: rtl/rtrt_pkg.sv
// Shared types and helpers for the ray-tracing front end.
//   vec3_t      : packed {x, y, z} vector of 16-bit signed components
//   seq_state_t : pixel_ray_sequencer control states
//   colour defaults and the primary-ray end-point helper
package rtrt_pkg;

  typedef struct packed {
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic signed [15:0] z;
  } vec3_t;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    GUARD,
    WAIT,
    WRITE,
    ADVANCE,
    FIN
  } seq_state_t;

  localparam logic [7:0] HIT_COLOR_DEF  = 8'hFF;
  localparam logic [7:0] MISS_COLOR_DEF = 8'h00;

  // Image-plane point for pixel (x, y): the camera offset by the pixel
  // position relative to the frame centre, pushed out by the focal distance.
  // All sums are 16-bit and wrap.
  function automatic vec3_t ray_end(input vec3_t       cam,
                                    input logic [15:0] x,
                                    input logic [15:0] y,
                                    input logic [15:0] h_half,
                                    input logic [15:0] v_half,
                                    input logic [15:0] focal);
    vec3_t r;
    r.x = cam.x + x - h_half;
    r.y = cam.y + y - v_half;
    r.z = cam.z + focal;
    return r;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster scan position tracker.
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : restart the scan at pixel (0,0)
//   advance    : step to the next pixel in raster order
//   addr       : linear pixel address y*H_RES+x, kept incrementally
//   x_nxt/y_nxt: coordinates the counter will hold after this cycle
//   last       : current pixel is the final one of the frame
module raster_counter #(
  parameter int H_RES  = 320,
  parameter int V_RES  = 240,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output logic [15:0]       x_nxt,
  output logic [15:0]       y_nxt,
  output logic              last
);

  logic [15:0]       x_q, x_d;
  logic [15:0]       y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic x_end;

  assign x_end = (x_q == 16'(H_RES - 1));
  assign last  = x_end && (y_q == 16'(V_RES - 1));

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    x_d    = x_q;
    y_d    = y_q;
    addr_d = addr_q;
    if (clear) begin
      x_d    = '0;
      y_d    = '0;
      addr_d = '0;
    end else if (advance) begin
      addr_d = addr_q + 1'b1;
      if (x_end) begin
        x_d = '0;
        // Wrap y on the final pixel so the counter rests in a sane state.
        y_d = last ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      addr_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      addr_q <= addr_d;
    end
  end

  assign addr  = addr_q;
  assign x_nxt = x_d;
  assign y_nxt = y_d;

endmodule

// File: rtl/pixel_ray_sequencer.sv
// Frame scanner feeding ray_sphere_intersection and the framebuffer.
// For each pixel in raster order: build a primary ray from the latched camera
// to the image-plane point, pulse isect_enable, wait (bounded) for
// isect_ready, then write a hit/miss byte through the fb_we/fb_ready port.
//   CLK, RESET_N      : clock, synchronous active-low reset
//   START, CAM        : frame request (IDLE only) and camera position
//   BUSY, DONE, ERR   : frame in progress, end-of-frame pulse, sticky timeout
//   ray_p0, ray_p1    : registered ray start/end presented to the intersector
//   isect_enable/ready/collide : intersector handshake and result
//   fb_addr/data/we/ready      : framebuffer write port with backpressure
module pixel_ray_sequencer
  import rtrt_pkg::*;
#(
  parameter int         H_RES      = 320,
  parameter int         V_RES      = 240,
  parameter int         FOCAL      = 256,
  parameter int         ADDR_W     = 17,
  parameter logic [7:0] HIT_COLOR  = HIT_COLOR_DEF,
  parameter logic [7:0] MISS_COLOR = MISS_COLOR_DEF,
  parameter int         TIMEOUT    = 63
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              START,
  input  vec3_t             CAM,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output vec3_t             ray_p0,
  output vec3_t             ray_p1,
  output logic              isect_enable,
  input  logic              isect_ready,
  input  logic              isect_collide,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_data,
  output logic              fb_we,
  input  logic              fb_ready
);

  // The wait counter only has to represent 0..TIMEOUT-1.
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  seq_state_t        state_q, state_d;
  vec3_t             cam_q, cam_d;
  vec3_t             ray_p0_q, ray_p0_d;
  vec3_t             ray_p1_q, ray_p1_d;
  logic [7:0]        data_q, data_d;
  logic              err_q, err_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;

  logic              cnt_clear;
  logic              cnt_adv;
  logic [15:0]       x_nxt;
  logic [15:0]       y_nxt;
  logic              last_pix;
  logic [ADDR_W-1:0] addr;

  raster_counter #(
    .H_RES  (H_RES),
    .V_RES  (V_RES),
    .ADDR_W (ADDR_W)
  ) u_raster (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .clear   (cnt_clear),
    .advance (cnt_adv),
    .addr    (addr),
    .x_nxt   (x_nxt),
    .y_nxt   (y_nxt),
    .last    (last_pix)
  );

  always_comb begin
    state_d   = state_q;
    cam_d     = cam_q;
    ray_p0_d  = ray_p0_q;
    ray_p1_d  = ray_p1_q;
    data_d    = data_q;
    err_d     = err_q;
    to_cnt_d  = to_cnt_q;
    cnt_clear = 1'b0;
    cnt_adv   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (START) begin
          cam_d     = CAM;
          err_d     = 1'b0;
          cnt_clear = 1'b1;
          state_d   = LAUNCH;
        end
      end
      LAUNCH: state_d = GUARD;
      GUARD: begin
        // READY may still be high from the previous ray this cycle; it is
        // deliberately not looked at until WAIT.
        to_cnt_d = '0;
        state_d  = WAIT;
      end
      WAIT: begin
        if (isect_ready) begin
          data_d  = isect_collide ? HIT_COLOR : MISS_COLOR;
          state_d = WRITE;
        end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          data_d  = MISS_COLOR;
          err_d   = 1'b1;
          state_d = WRITE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      WRITE: begin
        if (fb_ready) state_d = ADVANCE;
      end
      ADVANCE: begin
        cnt_adv = 1'b1;
        state_d = last_pix ? FIN : LAUNCH;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Rays are built on the way into LAUNCH from the coordinates the raster
    // counter is about to hold, so they are stable for the whole pixel.
    if (state_d == LAUNCH) begin
      ray_p0_d = cam_d;
      ray_p1_d = ray_end(cam_d, x_nxt, y_nxt, 16'(H_RES / 2), 16'(V_RES / 2),
                         16'(FOCAL));
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      cam_q    <= '0;
      ray_p0_q <= '0;
      ray_p1_q <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cam_q    <= cam_d;
      ray_p0_q <= ray_p0_d;
      ray_p1_q <= ray_p1_d;
      data_q   <= data_d;
      err_q    <= err_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  // Handshake outputs decode straight from the state register.
  assign BUSY         = (state_q != IDLE) && (state_q != FIN);
  assign DONE         = (state_q == FIN);
  assign ERR          = err_q;
  assign isect_enable = (state_q == LAUNCH);
  assign fb_we        = (state_q == WRITE);
  assign fb_addr      = addr;
  assign fb_data      = data_q;
  assign ray_p0       = ray_p0_q;
  assign ray_p1       = ray_p1_q;

endmodule

// File: tb/tb_pixel_ray_sequencer.sv
// Bench for pixel_ray_sequencer on a 4x2 frame: intersector responder,
// framebuffer capture and a pixel-level reference of the expected frame.
module tb_pixel_ray_sequencer;
  import rtrt_pkg::*;

  localparam int H    = 4;
  localparam int V    = 2;
  localparam int NPIX = H * V;
  localparam int FOC  = 256;
  localparam int AW   = 17;
  localparam int TO   = 63;

  logic          CLK      = 1'b0;
  logic          RESET_N  = 1'b0;
  logic          START    = 1'b0;
  vec3_t         CAM      = '0;
  logic          fb_ready = 1'b1;
  logic          BUSY, DONE, ERR, isect_enable, fb_we;
  vec3_t         ray_p0, ray_p1;
  logic [AW-1:0] fb_addr;
  logic [7:0]    fb_data;
  logic          isect_ready, isect_collide;

  pixel_ray_sequencer #(
    .H_RES(H), .V_RES(V), .FOCAL(FOC), .ADDR_W(AW),
    .HIT_COLOR(8'hFF), .MISS_COLOR(8'h00), .TIMEOUT(TO)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .CAM(CAM),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .ray_p0(ray_p0), .ray_p1(ray_p1),
    .isect_enable(isect_enable), .isect_ready(isect_ready),
    .isect_collide(isect_collide),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we), .fb_ready(fb_ready)
  );

  always #5 CLK = ~CLK;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- intersector responder ----------------
  // Per-frame script: result bit and READY latency (>= 3) for each pixel,
  // and the pixel whose READY never comes.
  bit   col_bits[NPIX];
  int   delay_arr[NPIX];
  int   hang_idx    = -1;
  bit   preload_req = 1'b0;
  bit   preload_col = 1'b0;

  logic m_ready = 1'b0, m_collide = 1'b0;
  int   launch_cnt = 0, cur_idx = 0, cnt = 0;
  bit   pend = 1'b0;
  vec3_t ray0_q[$], ray1_q[$];

  assign isect_ready   = m_ready;
  assign isect_collide = m_collide;

  // READY drops the cycle after ENABLE is accepted and rises delay cycles
  // after ENABLE, together with the new COLLIDE value.
  always @(posedge CLK) begin
    if (!RESET_N) begin
      pend      <= 1'b0;
      cnt       <= 0;
      m_ready   <= 1'b0;
      m_collide <= 1'b0;
    end else begin
      if (START) launch_cnt <= 0;
      if (isect_enable) begin
        ray0_q.push_back(ray_p0);
        ray1_q.push_back(ray_p1);
        cur_idx    <= launch_cnt;
        launch_cnt <= launch_cnt + 1;
      end
      pend <= isect_enable;
      if (preload_req) begin
        m_ready   <= 1'b1;
        m_collide <= preload_col;
      end else if (pend) begin
        m_ready <= 1'b0;
        cnt     <= (cur_idx == hang_idx) ? 0 : delay_arr[cur_idx] - 2;
      end else if (cnt != 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) begin
          m_ready   <= 1'b1;
          m_collide <= col_bits[cur_idx];
        end
      end
    end
  end

  // ---------------- framebuffer capture ----------------
  logic [AW-1:0] wa_q[$];
  logic [7:0]    wd_q[$];

  always @(posedge CLK) begin
    if (RESET_N && fb_we && fb_ready) begin
      wa_q.push_back(fb_addr);
      wd_q.push_back(fb_data);
    end
  end

  // ---------------- reference ----------------
  function automatic logic [7:0] exp_col(input int p);
    if (p == hang_idx) return 8'h00;
    return col_bits[p] ? 8'hFF : 8'h00;
  endfunction

  function automatic vec3_t exp_ray1(input vec3_t cam, input int p);
    vec3_t r;
    r.x = 16'(int'(cam.x) + (p % H) - H / 2);
    r.y = 16'(int'(cam.y) + (p / H) - V / 2);
    r.z = 16'(int'(cam.z) + FOC);
    return r;
  endfunction

  task automatic script_frame(input bit rand_col, input bit rand_dly);
    for (int p = 0; p < NPIX; p++) begin
      col_bits[p]  = rand_col ? bit'($urandom_range(0, 1)) : ((p % H) % 2 == 0);
      delay_arr[p] = rand_dly ? int'($urandom_range(3, 6)) : 3;
    end
  endtask

  task automatic check_writes(input string tag, input int base, input int count);
    check({tag, "_nwrites"}, 64'(wa_q.size() - base), 64'(count));
    for (int i = 0; i < count && base + i < wa_q.size(); i++) begin
      check({tag, "_addr"}, 64'(wa_q[base+i]), 64'(i));
      check({tag, "_data"}, 64'(wd_q[base+i]), 64'(exp_col(i)));
    end
  endtask

  task automatic check_rays(input string tag, input int base, input int count,
                            input vec3_t cam);
    check({tag, "_nrays"}, 64'(ray0_q.size() - base), 64'(count));
    for (int i = 0; i < count && base + i < ray0_q.size(); i++) begin
      check({tag, "_p0"}, 64'(ray0_q[base+i]), 64'(cam));
      check({tag, "_p1"}, 64'(ray1_q[base+i]), 64'(exp_ray1(cam, i)));
    end
  endtask

  // Returns at the negedge of the LAUNCH cycle of pixel 0.
  task automatic start_frame(input vec3_t cam);
    @(negedge CLK);
    CAM   = cam;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  // mode 0: fb_ready high; 1: ten-cycle stall on pixel 3; 2: random fb_ready.
  task automatic run_frame(input int mode, output int done_n,
                           output int pulses, output bit busy_bad);
    int n = 1;
    int stall = 0;
    logic [7:0] held = '0;
    done_n = -1; pulses = 0; busy_bad = 1'b0;
    while (n < 3000) begin
      if (DONE) begin
        pulses++;
        if (BUSY) busy_bad = 1'b1;
        done_n = n;
        break;
      end
      if (!BUSY) busy_bad = 1'b1;
      if (mode == 1 && fb_we && fb_addr == AW'(3) && stall < 10) begin
        if (stall == 0) held = fb_data;
        check("stall_addr", 64'(fb_addr), 64'(3));
        check("stall_data", 64'(fb_data), 64'(held));
        check("stall_no_enable", 64'(isect_enable), 64'(0));
        fb_ready = 1'b0;
        stall++;
      end else if (mode == 2) begin
        fb_ready = ($urandom_range(0, 3) != 0);
      end else begin
        fb_ready = 1'b1;
      end
      @(negedge CLK);
      n++;
    end
    fb_ready = 1'b1;
    if (mode == 1) check("stall_cycles", 64'(stall), 64'(10));
    repeat (3) begin
      @(negedge CLK);
      if (DONE) pulses++;
    end
  endtask

  int    done_n, pulses, wbase, rbase, k;
  bit    busy_bad;
  vec3_t cam;

  initial begin
    // ---- reset state ----
    RESET_N = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_busy", 64'(BUSY), 64'(0));
    check("rst_done", 64'(DONE), 64'(0));
    check("rst_err", 64'(ERR), 64'(0));
    check("rst_enable", 64'(isect_enable), 64'(0));
    check("rst_we", 64'(fb_we), 64'(0));
    check("rst_addr", 64'(fb_addr), 64'(0));
    check("rst_data", 64'(fb_data), 64'(0));
    check("rst_p0", 64'(ray_p0), 64'(0));
    check("rst_p1", 64'(ray_p1), 64'(0));
    RESET_N = 1'b1;

    // ---- frame A: centred camera, READY after 3, hit on even x ----
    script_frame(1'b0, 1'b0);
    hang_idx = -1;
    wbase = wa_q.size(); rbase = ray0_q.size();
    start_frame('0);
    run_frame(0, done_n, pulses, busy_bad);
    check("A_done_cycle", 64'(done_n), 64'(49));
    check("A_done_pulses", 64'(pulses), 64'(1));
    check("A_busy_vs_done", 64'(busy_bad), 64'(0));
    check("A_err", 64'(ERR), 64'(0));
    check_writes("A", wbase, NPIX);
    check_rays("A", rbase, NPIX, '0);

    // ---- frame B: offset camera, stale READY, fb stall, timeout ----
    script_frame(1'b1, 1'b1);
    col_bits[0] = 1'b0;
    hang_idx    = 2;
    preload_col = 1'b1;
    preload_req = 1'b1;
    @(negedge CLK);
    preload_req = 1'b0;
    cam.x = 16'sd100; cam.y = 16'sd50; cam.z = -16'sd10;
    wbase = wa_q.size(); rbase = ray0_q.size();
    start_frame(cam);
    run_frame(1, done_n, pulses, busy_bad);
    check("B_done_seen", 64'(done_n > 0), 64'(1));
    check("B_done_pulses", 64'(pulses), 64'(1));
    check("B_err_sticky", 64'(ERR), 64'(1));
    check("B_pix0_p0", 64'(ray0_q[rbase]), {16'h0, 16'd100, 16'd50, 16'hFFF6});
    check("B_pix0_p1", 64'(ray1_q[rbase]), {16'h0, 16'd98, 16'd49, 16'd246});
    check_writes("B", wbase, NPIX);
    check_rays("B", rbase, NPIX, cam);

    // ---- frame C: ERR clears on START, reset in WAIT of pixel 5 ----
    script_frame(1'b1, 1'b1);
    hang_idx = -1;
    cam.x = 16'($urandom); cam.y = 16'($urandom); cam.z = 16'($urandom);
    wbase = wa_q.size(); rbase = ray0_q.size();
    start_frame(cam);
    check("C_err_cleared", 64'(ERR), 64'(0));
    k = 0;
    while (ray0_q.size() < rbase + 6 && k < 500) begin
      fb_ready = ($urandom_range(0, 3) != 0);
      @(negedge CLK);
      k++;
    end
    check("C_reached_pix5", 64'(ray0_q.size() - rbase), 64'(6));
    fb_ready = 1'b1;
    @(negedge CLK);                 // WAIT of pixel 5
    RESET_N = 1'b0;
    @(negedge CLK);
    check("C_rst_busy", 64'(BUSY), 64'(0));
    check("C_rst_we", 64'(fb_we), 64'(0));
    check("C_rst_enable", 64'(isect_enable), 64'(0));
    check("C_rst_addr", 64'(fb_addr), 64'(0));
    RESET_N = 1'b1;
    pulses = 0;
    repeat (6) begin
      @(negedge CLK);
      if (DONE) pulses++;
    end
    check("C_no_done", 64'(pulses), 64'(0));
    check_writes("C", wbase, 5);

    // ---- frame D: random camera, results and backpressure ----
    script_frame(1'b1, 1'b1);
    cam.x = 16'($urandom); cam.y = 16'($urandom); cam.z = 16'($urandom);
    wbase = wa_q.size(); rbase = ray0_q.size();
    start_frame(cam);
    run_frame(2, done_n, pulses, busy_bad);
    check("D_done_seen", 64'(done_n > 0), 64'(1));
    check("D_done_pulses", 64'(pulses), 64'(1));
    check("D_busy_vs_done", 64'(busy_bad), 64'(0));
    check("D_err", 64'(ERR), 64'(0));
    check_writes("D", wbase, NPIX);
    check_rays("D", rbase, NPIX, cam);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pixel_ray_sequencer.md
Name: pixel_ray_sequencer

Overview:
- Upstream driver of ray_sphere_intersection: scans the frame pixel by pixel and builds one primary ray per pixel (camera origin to image-plane point).
- Launches the intersector through its ENABLE/READY handshake and waits for the result.
- Writes a hit/miss colour byte per pixel to the framebuffer write port, with backpressure.

Parameters:
- H_RES, 320, pixels per line
- V_RES, 240, lines per frame
- FOCAL, 256, signed z-offset of image plane from camera
- ADDR_W, 17, framebuffer address width; must satisfy 2^ADDR_W >= H_RES*V_RES
- HIT_COLOR, 8'hFF, pixel byte on collision
- MISS_COLOR, 8'h00, pixel byte on no collision
- TIMEOUT, 63, max cycles to wait for isect_ready

Ports:
- CLK  in  1  clock
- RESET_N  in  1  synchronous, active-low reset
- START  in  1  begin frame; sampled in IDLE only
- CAM  in  16x3 signed camera position {x,y,z}
- BUSY  out  1  frame in progress
- DONE  out  1  one-cycle pulse after the last pixel is written
- ERR  out  1  sticky; set on any intersector timeout; cleared on START
- ray_p0  out  16x3  ray start (latched CAM)
- ray_p1  out  16x3  ray end (image-plane point)
- isect_enable  out  1  one-cycle launch pulse
- isect_ready  in  1  intersector READY
- isect_collide  in  1  intersector COLLIDE
- fb_addr  out  ADDR_W  pixel address, y*H_RES+x
- fb_data  out  8  pixel byte
- fb_we  out  1  write request
- fb_ready  in  1  framebuffer accepts when fb_we && fb_ready

Behaviour:
- Reset (RESET_N low at a CLK edge) forces state IDLE and x=y=0.
  - Outputs go to: BUSY=0, DONE=0, ERR=0, isect_enable=0, fb_we=0, fb_addr=0, fb_data=0, ray_p0/ray_p1=0.
  - Reset mid-frame abandons the frame silently; no DONE.
- IDLE:
  - If START: latch CAM into the camera register, clear ERR, x=y=0, addr=0, BUSY=1, go LAUNCH.
  - START while BUSY is ignored.
- LAUNCH:
  - Drive ray_p0=cam.
  - Drive ray_p1 = {cam.x + x - H_RES/2, cam.y + y - V_RES/2, cam.z + FOCAL}.
  - All arithmetic is 16-bit two's complement and wraps; no saturation.
  - ray_p0/ray_p1 are registered and stable from LAUNCH until the pixel is written.
  - isect_enable=1 for exactly this cycle; go GUARD.
- GUARD, one cycle: ignore isect_ready. The intersector clears READY only on the cycle after it accepts ENABLE, so a stale high READY must not be sampled. Reset the timeout counter; go WAIT.
- WAIT:
  - If isect_ready: capture fb_data = isect_collide ? HIT_COLOR : MISS_COLOR; go WRITE.
  - Otherwise, if the counter reaches TIMEOUT: fb_data=MISS_COLOR, ERR=1, go WRITE.
  - Nominal WAIT dwell is 2 cycles, giving 6 cycles per pixel with no backpressure.
- WRITE:
  - fb_we=1 with fb_addr/fb_data held stable until fb_ready.
  - On fb_we && fb_ready: go ADVANCE.
  - fb_ready low holds indefinitely; no timeout applies.
- ADVANCE:
  - addr+1; x+1. If x==H_RES-1 then x=0 and y+1.
  - If x==H_RES-1 && y==V_RES-1: go FIN. Otherwise go LAUNCH.
  - addr is updated incrementally; no multiplier.
- FIN: DONE=1 for one cycle, BUSY=0, go IDLE. START is accepted on the next cycle.
- isect_enable is never asserted outside LAUNCH.
- Exactly one fb write occurs per pixel, in raster order.
- Total writes per frame = H_RES*V_RES.

Decomposition:
- Package rtrt_pkg:
  - vec3_t (16-bit signed x3)
  - seq_state_t enum {IDLE, LAUNCH, GUARD, WAIT, WRITE, ADVANCE, FIN}
  - colour constants
- Sub-module raster_counter: x/y/addr counters with advance and last-pixel flag; instantiated once.

Test Plan:
- H_RES=4, V_RES=2, CAM={0,0,0}, intersector model READY 3 cycles after ENABLE, collide on even x -> 8 writes at addr 0..7, data FF,00,FF,00,FF,00,FF,00; DONE is one pulse; BUSY falls with DONE.
- Pixel (0,0), CAM={100,50,-10} -> ray_p0={100,50,-10}, ray_p1={98,49,246}.
- Model holds READY=1 from a previous ray -> first pixel result is not taken before GUARD completes; result equals the new collide value.
- fb_ready low for 10 cycles on pixel 3 -> fb_addr=3 and fb_data held; no isect_enable during the stall; pixel 4 follows.
- Model never asserts READY on pixel 2 -> after TIMEOUT cycles, addr 2 gets 00 and ERR=1; the frame completes; ERR clears on the next START.
- RESET_N low in WAIT of pixel 5 -> next cycle BUSY=0, fb_we=0, isect_enable=0; no DONE; a new START restarts at addr 0.
